// File: rtl/clk_div_ctrl_if.sv
// Configuration channel of the clock divider: a half-period word offered
// with a valid/ready handshake, plus the rejection pulse for a zero word.
interface clk_div_ctrl_if #(
  parameter int CNT_W = 8
) ();
  logic             cfgValid;
  logic [CNT_W-1:0] cfgHalf;
  logic             cfgReady;
  logic             cfgErr;

  modport master (
    output cfgValid,
    output cfgHalf,
    input  cfgReady,
    input  cfgErr
  );

  modport slave (
    input  cfgValid,
    input  cfgHalf,
    output cfgReady,
    output cfgErr
  );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider. outClk has a half-period of 'active' input
// cycles. New ratios and stop requests are applied only on a falling edge
// of outClk, so the output never shows a shortened high pulse.
//
// state | meaning
// IDLE  | outClk held low, config words load 'active' directly
// RUN   | dividing; new config words are held until the next falling edge
// STOP  | en dropped while outClk high; finish the high phase, then IDLE
module clk_div_ctrl #(
  parameter int CNT_W    = 8,
  parameter int RST_HALF = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  clk_div_ctrl_if.slave cfg,
  output logic          outClk,
  output logic          outRise,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_INIT = CNT_W'(RST_HALF);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_v_q, pend_v_d;
  logic             out_clk_q, out_clk_d;
  logic             out_rise_q, out_rise_d;
  logic             cfg_err_q, cfg_err_d;

  logic accept, cfg_zero, counting, tc, fall_edge;

  assign accept    = cfg.cfgValid && !pend_v_q;
  assign cfg_zero  = (cfg.cfgHalf == '0);
  assign counting  = (state_q != ST_IDLE);
  // active_q is never zero, so active_q - 1 cannot wrap
  assign tc        = (cnt_q == active_q - ONE);
  assign fall_edge = counting && tc && out_clk_q;

  // Next-state logic: phase counter, held config word and FSM
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    cnt_d      = cnt_q;
    out_clk_d  = out_clk_q;
    out_rise_d = 1'b0;
    cfg_err_d  = accept && cfg_zero;

    if (counting) begin
      if (tc) begin
        cnt_d      = '0;
        out_clk_d  = !out_clk_q;
        out_rise_d = !out_clk_q;
      end else begin
        cnt_d = cnt_q + ONE;
      end
      if (fall_edge && pend_v_q) begin
        active_d = pend_q;
        pend_v_d = 1'b0;
      end
      // accept implies pend_v_q == 0, so this never collides with the apply above;
      // a word taken on a falling edge therefore waits for the next one
      if (accept && !cfg_zero) begin
        pend_d   = cfg.cfgHalf;
        pend_v_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (accept && !cfg_zero) begin
          active_d = cfg.cfgHalf;
        end
        if (en) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          out_clk_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!en) begin
          if (!out_clk_q) begin
            // low phase: stop at once, suppressing any rising toggle due now
            state_d    = ST_IDLE;
            cnt_d      = '0;
            out_clk_d  = 1'b0;
            out_rise_d = 1'b0;
          end else if (fall_edge) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (en) begin
          state_d = ST_RUN;
        end else if (fall_edge) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Entering IDLE flushes any held word, including one accepted on this edge
    if (state_d == ST_IDLE && state_q != ST_IDLE && pend_v_d) begin
      active_d = pend_d;
      pend_v_d = 1'b0;
    end
  end

  // State registers; reset forces outClk low immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      active_q   <= HALF_INIT;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      cnt_q      <= '0;
      out_clk_q  <= 1'b0;
      out_rise_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      cnt_q      <= cnt_d;
      out_clk_q  <= out_clk_d;
      out_rise_q <= out_rise_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign cfg.cfgReady = !pend_v_q;
  assign cfg.cfgErr   = cfg_err_q;
  assign outClk       = out_clk_q;
  assign outRise      = out_rise_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl. The reference model describes the divided clock
// arithmetically: after an origin edge (run start or a falling edge that
// applied a new ratio) with half-period A, the output after k edges is
// (k/A) odd, and outRise marks k mod 2A == A. A held word is applied at the
// first multiple of 2A strictly after the accepting edge.
module tb_clk_div_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic outClk, outRise, busy;

  clk_div_ctrl_if #(.CNT_W(8)) cfg_if ();

  clk_div_ctrl #(.CNT_W(8), .RST_HALF(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .cfg    (cfg_if.slave),
    .outClk (outClk),
    .outRise(outRise),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int a_cur = 2;     // half-period in use
  int a_next = 0;    // held half-period
  int k = 0;         // edges since the current origin
  int apply_k = -1;  // edge (in k units) at which the held word applies
  bit err_exp = 1'b0;

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b (k=%0d half=%0d)", tag, obs, exp_v, k, a_cur);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One running edge checked against the arithmetic model
  task automatic tick();
    step();
    k++;
    chk("outClk", outClk, ((k / a_cur) % 2) == 1);
    chk("outRise", outRise, (k % (2 * a_cur)) == a_cur);
    chk("busy_run", busy, 1'b1);
    chk("cfgErr", cfg_if.cfgErr, err_exp);
    err_exp = 1'b0;
    if (apply_k == k) begin
      a_cur   = a_next;
      k       = 0;
      apply_k = -1;
    end
    chk("cfgReady", cfg_if.cfgReady, apply_k < 0);
  endtask

  task automatic offer_tick(input int b);
    apply_k = ((k + 1) / (2 * a_cur) + 1) * 2 * a_cur;
    a_next  = b;
    cfg_if.cfgValid = 1'b1;
    cfg_if.cfgHalf  = 8'(b);
    tick();
    cfg_if.cfgValid = 1'b0;
  endtask

  task automatic offer_zero_tick();
    cfg_if.cfgValid = 1'b1;
    cfg_if.cfgHalf  = 8'd0;
    err_exp = 1'b1;
    tick();
    cfg_if.cfgValid = 1'b0;
  endtask

  task automatic start();
    en = 1'b1;
    step();
    k = 0;
    chk("start_busy", busy, 1'b1);
    chk("start_outClk", outClk, 1'b0);
    chk("start_outRise", outRise, 1'b0);
  endtask

  // Drop en: a low phase ends at once, a high phase runs to its falling edge
  task automatic stop();
    bit hi;
    bit exp_clk;
    bit idle;
    en = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 600 && !idle; i++) begin
      hi = ((k / a_cur) % 2) == 1;
      step();
      k++;
      if (!hi) begin
        exp_clk = 1'b0;
        idle = 1'b1;
      end else begin
        exp_clk = ((k / a_cur) % 2) == 1;
        idle = !exp_clk;
      end
      chk("stop_outClk", outClk, exp_clk);
      chk("stop_busy", busy, !idle);
      chk("stop_outRise", outRise, 1'b0);
    end
    if (apply_k >= 0) begin
      a_cur   = a_next;
      apply_k = -1;
    end
    chk("stop_cfgReady", cfg_if.cfgReady, 1'b1);
  endtask

  task automatic cfg_idle(input int b);
    cfg_if.cfgValid = 1'b1;
    cfg_if.cfgHalf  = 8'(b);
    step();
    cfg_if.cfgValid = 1'b0;
    if (b != 0) a_cur = b;
    chk("idle_cfgErr", cfg_if.cfgErr, b == 0);
    chk("idle_cfgReady", cfg_if.cfgReady, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_outClk", outClk, 1'b0);
    if (b == 0) begin
      step();
      chk("idle_cfgErr_clr", cfg_if.cfgErr, 1'b0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cfg_if.cfgValid = 1'b0;
    cfg_if.cfgHalf  = 8'd0;

    // Reset state
    #3;
    chk("rst_outClk", outClk, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outRise", outRise, 1'b0);
    chk("rst_cfgErr", cfg_if.cfgErr, 1'b0);
    #20 rst_n = 1'b1;
    step();
    chk("rel_cfgReady", cfg_if.cfgReady, 1'b1);
    chk("rel_busy", busy, 1'b0);
    chk("rel_outClk", outClk, 1'b0);

    // Default divide-by-4
    start();
    repeat (12) tick();

    // Zero half-period rejected, period unchanged
    offer_zero_tick();
    repeat (8) tick();

    // Mid-run change to 3 while outClk is high
    for (int i = 0; i < 8 && (k % 4) != 2; i++) tick();
    offer_tick(3);
    repeat (14) tick();

    // Stop in the second high cycle, half-period 3
    for (int i = 0; i < 12 && (k % 6) != 4; i++) tick();
    stop();

    // Stop during a low phase
    start();
    tick();
    stop();

    // Brief en drop in a high phase: STOP then back to RUN, uninterrupted
    start();
    for (int i = 0; i < 6 && k != 3; i++) tick();
    en = 1'b0;
    tick();
    en = 1'b1;
    repeat (10) tick();

    // Word accepted on a falling edge waits for the next falling edge
    for (int i = 0; i < 12 && ((k + 1) % (2 * a_cur)) != 0; i++) tick();
    offer_tick(4);
    for (int i = 0; i < 40 && apply_k >= 0; i++) tick();
    repeat (10) tick();
    stop();

    // Zero in IDLE, then extreme ratios
    cfg_idle(0);
    cfg_idle(1);
    start();
    repeat (10) tick();
    stop();
    cfg_idle(255);
    start();
    repeat (1100) tick();
    stop();

    // Randomized runs
    for (int it = 0; it < 10; it++) begin
      if (it % 2 == 0) cfg_idle(int'($urandom_range(1, 12)));
      start();
      repeat ($urandom_range(0, 10)) tick();
      if ($urandom_range(0, 3) == 0) offer_zero_tick();
      else offer_tick(int'($urandom_range(1, 12)));
      repeat ($urandom_range(0, 2 * a_cur + 2)) tick();
      stop();
    end

    // Reset mid-operation with a held word and outClk high
    cfg_idle(5);
    start();
    for (int i = 0; i < 8 && k != 4; i++) tick();
    offer_tick(7);
    chk("pre_rst_outClk", outClk, 1'b1);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("mid_rst_outClk", outClk, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_outRise", outRise, 1'b0);
    chk("mid_rst_cfgReady", cfg_if.cfgReady, 1'b1);
    #2 rst_n = 1'b1;
    a_cur   = 2;
    apply_k = -1;
    k       = 0;
    start();
    repeat (9) tick();
    stop();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
